// File: rtl/ripple_capture_pkg.sv
// Shared types and constants for the ripple-counter capture block.
// Holds the capture FSM states and the saturating increment helper.
package ripple_capture_pkg;

  localparam int COUNT_W   = 4;
  localparam int DELTA_W   = 8;
  localparam int DELTA_MAX = 255;

  typedef enum logic [1:0] {
    INIT,
    TRACK,
    PEND
  } cap_state_t;

  // One bit wider than delta so the caller can see saturation.
  function automatic logic [DELTA_W:0] delta_add(input logic [DELTA_W-1:0] acc,
                                                 input logic [COUNT_W-1:0] step);
    return {1'b0, acc} + {{(DELTA_W + 1 - COUNT_W){1'b0}}, step};
  endfunction

endpackage

// File: rtl/ripple_count_capture_if.sv
// Valid/ready channel carrying pending counter increments to a reader.
interface ripple_count_capture_if;
  import ripple_capture_pkg::*;

  logic               delta_valid;
  logic [DELTA_W-1:0] delta;
  logic               delta_ready;

  modport master (output delta_valid, output delta, input delta_ready);
  modport slave  (input delta_valid, input delta, output delta_ready);

endinterface

// File: rtl/ripple_count_capture_sync_filter.sv
// Two-flop synchronizer for the ripple count plus a stability filter that
// pulses accept once per run of STABLE_CYCLES identical samples.
module count_sync_filter
  import ripple_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [COUNT_W-1:0] count_in,
  output logic               accept,
  output logic [COUNT_W-1:0] value
);

  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

  logic [COUNT_W-1:0] s1, s2;
  logic [3:0]         run, run_next;
  logic               fresh, accept_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fresh    = (s1 != s2);
    run_next = run;
    if (!enable)              run_next = '0;
    else if (fresh)           run_next = 4'd1;
    else if (run != RUN_MAX)  run_next = run + 4'd1;
    // A fresh run can land on RUN_MAX immediately when STABLE_CYCLES is 1.
    accept_next = enable && (run_next == RUN_MAX) && (fresh || (run != RUN_MAX));
  end

  // NOTE: sequential state uses non-blocking assignments so s2 samples the old s1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1     <= '0;
      s2     <= '0;
      run    <= '0;
      accept <= 1'b0;
    end else begin
      s1     <= count_in;
      s2     <= s1;
      run    <= run_next;
      accept <= accept_next;
    end
  end

  // s2 updates on the same edge as accept, so it already holds the accepted value.
  assign value = s2;

endmodule

// File: rtl/ripple_count_capture.sv
// Turns filtered ripple-counter values into mod-16 increments, accumulates a
// running total and offers coalesced increments over a valid/ready channel.
module ripple_count_capture
  import ripple_capture_pkg::*;
#(
  parameter int TOTAL_W       = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [COUNT_W-1:0]  count_in,
  input  logic                enable,
  input  logic                clear,
  ripple_count_capture_if.master handshake,
  output logic [TOTAL_W-1:0]  total,
  output logic                overflow,
  output logic                lost
);

  logic               accept;
  logic [COUNT_W-1:0] value;

  count_sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .count_in (count_in),
    .accept   (accept),
    .value    (value)
  );

  cap_state_t         state_q, state_n;
  logic [COUNT_W-1:0] base_q, base_n;
  logic [TOTAL_W-1:0] total_q, total_n;
  logic [DELTA_W-1:0] delta_q, delta_n;
  logic               valid_q, valid_n;
  logic               ovf_q, ovf_n;
  logic               lost_q, lost_n;

  logic [COUNT_W-1:0] step;
  logic               take_step, xfer;
  logic [TOTAL_W:0]   total_sum;
  logic [DELTA_W:0]   delta_sum;

  always_comb begin
    step      = value - base_q;
    take_step = accept && (step != '0) && (state_q != INIT);
    xfer      = valid_q && handshake.delta_ready;
    total_sum = {1'b0, total_q} + {{(TOTAL_W + 1 - COUNT_W){1'b0}}, step};
    delta_sum = delta_add(delta_q, step);

    state_n = state_q;
    base_n  = base_q;
    total_n = total_q;
    delta_n = delta_q;
    valid_n = valid_q;
    ovf_n   = ovf_q;
    lost_n  = lost_q;

    if (clear) begin
      state_n = INIT;
      base_n  = '0;
      total_n = '0;
      delta_n = '0;
      valid_n = 1'b0;
      ovf_n   = 1'b0;
      lost_n  = 1'b0;
    end else begin
      if (take_step) begin
        base_n  = value;
        total_n = total_sum[TOTAL_W-1:0];
        if (total_sum[TOTAL_W]) ovf_n = 1'b1;
      end
      case (state_q)
        INIT: begin
          if (accept) begin
            base_n  = value;
            state_n = TRACK;
          end
        end
        TRACK: begin
          if (take_step) begin
            delta_n = {{(DELTA_W - COUNT_W){1'b0}}, step};
            valid_n = 1'b1;
            state_n = PEND;
          end
        end
        PEND: begin
          if (take_step && xfer) begin
            // The old increment leaves this cycle; the new step starts fresh.
            delta_n = {{(DELTA_W - COUNT_W){1'b0}}, step};
          end else if (take_step) begin
            if (delta_sum > (DELTA_W + 1)'(DELTA_MAX)) begin
              delta_n = DELTA_W'(DELTA_MAX);
              lost_n  = 1'b1;
            end else begin
              delta_n = delta_sum[DELTA_W-1:0];
            end
          end else if (xfer) begin
            delta_n = '0;
            valid_n = 1'b0;
            state_n = TRACK;
          end
        end
        default: state_n = INIT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      base_q  <= '0;
      total_q <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      base_q  <= base_n;
      total_q <= total_n;
      delta_q <= delta_n;
      valid_q <= valid_n;
      ovf_q   <= ovf_n;
      lost_q  <= lost_n;
    end
  end

  assign handshake.delta_valid = valid_q;
  assign handshake.delta       = delta_q;
  assign total                 = total_q;
  assign overflow              = ovf_q;
  assign lost                  = lost_q;

endmodule

// File: doc/ripple_count_capture.md
# ripple_count_capture

Downstream consumer of the 4-bit ripple counter. It brings the asynchronously settling `count` bits into the `clock` domain and rejects ripple glitches with a stability filter. It converts accepted count changes into modulo-16 increments, which it accumulates into a wide running total. Increments are presented to a downstream reader over a valid/ready handshake, with coalescing under backpressure.

## Interface
- `TOTAL_W`, 16: running-total width, range 5..32.
- `STABLE_CYCLES`, 2: consecutive identical synchronized samples required to accept a value, range 1..15.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low. All state clears while low.
- `count_in`  in  4  ripple-counter output, asynchronous to `clock`.
- `enable`  in  1  0 blocks new acceptances; the handshake keeps working.
- `clear`  in  1  synchronous clear of total, flags, pending increment and baseline.
- `delta_valid`  out  1  pending increment available.
- `delta`  out  8  pending increment, saturating at 255.
- `delta_ready`  in  1  reader accepts `delta` when high together with `delta_valid`.
- `total`  out  `TOTAL_W`  running sum of accepted increments, modulo 2^`TOTAL_W`.
- `overflow`  out  1  sticky; set on a carry out of `total`.
- `lost`  out  1  sticky; set when `delta` saturates.

## Operation
- Reset values: `s1`, `s2`, run counter, baseline, `total`, `delta` all 0; `delta_valid`, `overflow` and `lost` 0; state INIT.
- Synchronizer: `s1` <= `count_in`, then `s2` <= `s1`.
- Filter run counter:
  - Reset to 1 when `s2` differs from its previous value.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
  - Held at 0 while `enable`=0.
- Acceptance: fires exactly once per run, in the cycle the run counter reaches `STABLE_CYCLES`. The accepted value is `v`.
- Step: `step` = (`v` − baseline) mod 16, 4-bit. A step of 0 is ignored.
- State INIT: an acceptance loads baseline <= `v`, produces no increment, and moves to TRACK.
- State TRACK: a nonzero step loads baseline <= `v`, `total` += `step`, `delta` <= `step`, `delta_valid` <= 1, and moves to PEND.
- State PEND: `delta_valid`=1 and `delta` is held stable until a transfer.
  - Nonzero step without a transfer: `total` += `step`; `delta` <= min(`delta`+`step`, 255). If the sum exceeds 255, `lost` <= 1.
  - Transfer without a step: `delta_valid` <= 0, `delta` <= 0, move to TRACK.
  - Transfer and nonzero step in the same cycle: `delta` <= `step`, stay in PEND, `delta_valid` stays 1.
- `total` wraps on addition. A carry out sets `overflow`.
- `clear`=1 has priority over every update. Next state:
  - `total`, `delta`, `delta_valid`, `overflow`, `lost` all 0.
  - State INIT, so the next accepted value becomes the new baseline.
  - Synchronizer and filter keep running.
- `reset` asserted mid-PEND: the pending increment is discarded, with all outputs at their reset values immediately.

## Timing
- Latency: `count_in` stable before rising edge *t*. Acceptance, the `total` update and `delta_valid` rise are all visible after edge *t*+1+`STABLE_CYCLES`.
- A `count_in` value held for fewer than `STABLE_CYCLES` synchronized cycles is never accepted.
- Handshake: a transfer is `delta_valid` && `delta_ready` at a rising edge. `delta_valid` falls one cycle after a transfer unless a step coalesces in the same cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `ripple_capture_pkg`:
  - State enum `cap_state_t` with states INIT, TRACK, PEND.
  - `COUNT_W`=4, `DELTA_W`=8, `DELTA_MAX`=255.
- Sub-module `count_sync_filter`:
  - Two-flop synchronizer plus run counter.
  - Outputs `accept` (1-cycle pulse) and `value` [3:0].
- The parent holds the FSM, the accumulator and the handshake registers.

## Test plan
- Reset low, then `count_in`=5 held → `total`=0, `delta_valid`=0, state TRACK with baseline 5. No increment is produced.
- Baseline 5, `count_in`=9 held with `delta_ready`=1 → after `STABLE_CYCLES`+1 edges, `delta_valid`=1, `delta`=4, `total`=4. `delta_valid`=0 on the next cycle.
- Wrap: baseline 14, `count_in`=2 → `delta`=4. A 1-cycle glitch value 7 before a stable 8 yields only the step to 8.
- Backpressure: `delta_ready`=0, 20 steps of 15 → `delta`=255, `lost`=1, `total`=300. A later transfer drops `delta_valid`.
- `TOTAL_W`=8, `total`=250 plus a step of 10 → `total`=4, `overflow`=1. Then `clear` → everything is 0, and the next accepted value only sets the baseline.
- `reset` pulsed low in PEND with `delta`=6 → `delta_valid`=0 and `total`=0 immediately. Operation restarts in INIT.
